// File: rtl/temporal_encoder_pkg.sv
// Shared definitions for the race-logic temporal encoder and its gamma framing.
package temporal_pkg;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_PULSE,
    ST_DONE
  } enc_state_t;

  // Width of a field that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned slot_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Values at or above this threshold encode "no spike"; the last slot is reserved for reset.
  function automatic int unsigned null_threshold(input int unsigned gamma_cycle_width);
    return gamma_cycle_width - 1;
  endfunction

endpackage

// File: rtl/temporal_encoder_gamma_counter.sv
// Gamma framing: free-running slot counter, registered reset strobe in the last slot.
module gamma_counter
  import temporal_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned VAL_W             = slot_width(GAMMA_CYCLE_WIDTH)
) (
  input  logic             aclk,
  input  logic             grst,
  output logic [VAL_W-1:0] slot,
  output logic             gamma_rst,
  output logic             boundary
);

  localparam logic [VAL_W-1:0] LAST_SLOT = VAL_W'(GAMMA_CYCLE_WIDTH - 1);

  logic [VAL_W-1:0] r_slot;
  logic [VAL_W-1:0] w_slot_nxt;
  logic             r_gamma_rst;

  always_comb begin
    w_slot_nxt = (r_slot == LAST_SLOT) ? '0 : r_slot + VAL_W'(1);
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      r_slot      <= '0;
      r_gamma_rst <= 1'b0;
    end else begin
      r_slot      <= w_slot_nxt;
      r_gamma_rst <= (w_slot_nxt == LAST_SLOT);
    end
  end

  assign slot      = r_slot;
  assign gamma_rst = r_gamma_rst;
  assign boundary  = r_gamma_rst;

endmodule

// File: rtl/temporal_encoder.sv
// Binary-to-race-logic encoder: one pulse per gamma, leading edge at slot == value.
// Optional macro HOLD_LAST_EN: re-emit the last value every gamma while no new value arrives.
module temporal_encoder
  import temporal_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic             aclk,
  input  logic             grst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  input  logic             in_null,
  output logic [VAL_W-1:0] slot,
  output logic             gamma_rst,
  output logic             pulse_out
);

  localparam int unsigned      CNT_W     = slot_width(PULSE_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [VAL_W-1:0] LAST_SLOT = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [VAL_W-1:0] NULL_VAL  = VAL_W'(null_threshold(GAMMA_CYCLE_WIDTH));

  logic [VAL_W-1:0] w_slot;
  logic [VAL_W-1:0] w_slot_nxt;
  logic             w_boundary;
  logic             w_xfer;
  logic             w_pend_full_nxt;

  logic             r_in_ready;
  logic             r_pend_full;
  logic [VAL_W-1:0] r_pend_val;
  logic             r_pend_null;
  logic [VAL_W-1:0] r_act_val;
  logic             r_act_null;
  logic [VAL_W-1:0] w_act_val_nxt;
  logic             w_act_null_nxt;

  enc_state_t       r_state;
  enc_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;

  gamma_counter #(
    .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
    .VAL_W            (VAL_W)
  ) u_gamma_counter (
    .aclk     (aclk),
    .grst     (grst),
    .slot     (w_slot),
    .gamma_rst(gamma_rst),
    .boundary (w_boundary)
  );

  assign w_slot_nxt      = w_boundary ? '0 : w_slot + VAL_W'(1);
  assign w_xfer          = in_valid && r_in_ready;
  assign w_pend_full_nxt = w_xfer || (r_pend_full && !w_boundary);

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      r_in_ready  <= 1'b1;
      r_pend_full <= 1'b0;
      r_pend_val  <= '0;
      r_pend_null <= 1'b1;
      r_act_val   <= '0;
      r_act_null  <= 1'b1;
    end else begin
      r_in_ready  <= !w_pend_full_nxt;
      r_pend_full <= w_pend_full_nxt;
      if (w_xfer) begin
        r_pend_val  <= in_value;
        r_pend_null <= in_null || (in_value >= NULL_VAL);
      end
      r_act_val  <= w_act_val_nxt;
      r_act_null <= w_act_null_nxt;
    end
  end

  always_comb begin
    w_act_val_nxt  = r_act_val;
    w_act_null_nxt = r_act_null;
    if (w_boundary) begin
      if (r_pend_full) begin
        w_act_val_nxt  = r_pend_val;
        w_act_null_nxt = r_pend_null;
      end else begin
`ifdef HOLD_LAST_EN
        w_act_null_nxt = r_act_null;
`else
        w_act_null_nxt = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      r_state <= ST_WAIT;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // The boundary evaluates against the incoming active value so a value of 0 pulses in slot 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_boundary) begin
      if (!w_act_null_nxt && (w_act_val_nxt == '0)) begin
        w_state_nxt = ST_PULSE;
        w_cnt_nxt   = CNT_LOAD;
      end else begin
        w_state_nxt = ST_WAIT;
      end
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (!r_act_null && (w_slot_nxt == r_act_val)) begin
            w_state_nxt = ST_PULSE;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
        ST_PULSE: begin
          if ((r_cnt == '0) || (w_slot_nxt == LAST_SLOT)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_DONE;
      endcase
    end
  end

  always_comb begin
    w_pulse_nxt = (w_state_nxt == ST_PULSE);
  end

  assign in_ready  = r_in_ready;
  assign slot      = w_slot;
  assign pulse_out = r_pulse;

endmodule
